uart_massiv_transaction_ctrl: RTL

UART_MASSIV_TRANSACTION_CTRL -- requirements
Module: uart_massiv_transaction_ctrl

---
 rtl/uart_massiv_transaction_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_massiv_transaction_ctrl.sv
// uart_massiv_transaction_ctrl: sequences one request/response transaction
// over a UART massiv block (clear RX buffer, launch TX, wait for the reply).
// Optional build macro: UART_MASSIV_CTRL_TIMEOUT_EN enables the reply
// timeout (status 01 after TIMEOUT_CYCLES clocks in WAIT_RX).
module uart_massiv_transaction_ctrl #(
    parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int unsigned TX_MASSIV_DEEP           = 2,
    parameter int unsigned RX_MASSIV_DEEP           = 2,
    parameter int unsigned TIMEOUT_CYCLES           = 65535,
    localparam int unsigned TX_W   = NUM_OF_DATA_BITS_IN_PACK * TX_MASSIV_DEEP,
    localparam int unsigned RX_W   = NUM_OF_DATA_BITS_IN_PACK * RX_MASSIV_DEEP,
    localparam int unsigned TXC_W  = $clog2(TX_MASSIV_DEEP) + 1,
    localparam int unsigned RXC_W  = $clog2(RX_MASSIV_DEEP) + 1,
    localparam int unsigned RXE_W  = RX_MASSIV_DEEP
) (
    input  logic             IN_CLOCK,
    input  logic             IN_RESET,
    input  logic             IN_REQ_VALID,
    output logic             OUT_REQ_READY,
    input  logic [TX_W-1:0]  IN_REQ_TX_DATA,
    input  logic [TXC_W-1:0] IN_REQ_TX_COUNT,
    input  logic [RXC_W-1:0] IN_REQ_RX_COUNT,
    output logic             OUT_RSP_VALID,
    input  logic             IN_RSP_READY,
    output logic [RX_W-1:0]  OUT_RSP_RX_DATA,
    output logic [1:0]       OUT_RSP_STATUS,
    output logic [TX_W-1:0]  OUT_TX_DATA_MASSIV,
    output logic [TXC_W-1:0] OUT_TX_NUMBER_OF_PACKS_TO_SEND,
    output logic             OUT_TX_LAUNCH,
    output logic             OUT_RX_CLEAR_BUFFER,
    input  logic             IN_TX_ACTIVE,
    input  logic             IN_TX_DONE,
    input  logic [RX_W-1:0]  IN_RX_DATA_MASSIV,
    input  logic [RXE_W-1:0] IN_RX_ERROR,
    input  logic [RXC_W-1:0] IN_RX_NUM_OF_DATA_PACKS_READY
);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_RX_ERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_TX = 3'd3,
        WAIT_RX = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t           state;
    logic [RXC_W-1:0] rx_cnt_q;
    logic             rx_done;
    logic [1:0]       rx_status;

`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt_q;
`else
    // Timeout limit has no effect when the reply timeout is not built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Counts saturate to the massiv depth so the UART block never over-runs.
    logic [TXC_W-1:0] tx_cnt_sat;
    logic [RXC_W-1:0] rx_cnt_sat;
    assign tx_cnt_sat = (IN_REQ_TX_COUNT > TXC_W'(TX_MASSIV_DEEP)) ?
                        TXC_W'(TX_MASSIV_DEEP) : IN_REQ_TX_COUNT;
    assign rx_cnt_sat = (IN_REQ_RX_COUNT > RXC_W'(RX_MASSIV_DEEP)) ?
                        RXC_W'(RX_MASSIV_DEEP) : IN_REQ_RX_COUNT;

    // Reply completion decision for WAIT_RX; error outranks completion.
    always_comb begin
        rx_done   = 1'b0;
        rx_status = ST_OK;
        if (rx_cnt_q == '0) begin
            rx_done = 1'b1;
        end else if (|IN_RX_ERROR) begin
            rx_done   = 1'b1;
            rx_status = ST_RX_ERR;
        end else if (IN_RX_NUM_OF_DATA_PACKS_READY >= rx_cnt_q) begin
            rx_done = 1'b1;
`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
        end else if ((32'(timeout_cnt_q) + 32'd1) >= TIMEOUT_CYCLES) begin
            rx_done   = 1'b1;
            rx_status = ST_TIMEOUT;
`endif
        end
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state                          <= IDLE;
            OUT_REQ_READY                  <= 1'b0;
            OUT_RSP_VALID                  <= 1'b0;
            OUT_RSP_STATUS                 <= ST_OK;
            OUT_RSP_RX_DATA                <= '0;
            OUT_TX_LAUNCH                  <= 1'b0;
            OUT_RX_CLEAR_BUFFER            <= 1'b0;
            OUT_TX_DATA_MASSIV             <= '0;
            OUT_TX_NUMBER_OF_PACKS_TO_SEND <= '0;
            rx_cnt_q                       <= '0;
`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
            timeout_cnt_q                  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (OUT_REQ_READY && IN_REQ_VALID) begin
                        OUT_TX_DATA_MASSIV             <= IN_REQ_TX_DATA;
                        OUT_TX_NUMBER_OF_PACKS_TO_SEND <= tx_cnt_sat;
                        rx_cnt_q                       <= rx_cnt_sat;
                        OUT_REQ_READY                  <= 1'b0;
                        OUT_RX_CLEAR_BUFFER            <= 1'b1;
                        state                          <= CLEAR;
                    end else begin
                        OUT_REQ_READY <= 1'b1;
                    end
                end
                CLEAR: begin
                    OUT_RX_CLEAR_BUFFER <= 1'b0;
                    state               <= LAUNCH;
                end
                LAUNCH: begin
                    if (OUT_TX_NUMBER_OF_PACKS_TO_SEND == '0) begin
                        state <= WAIT_RX;
`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
                        timeout_cnt_q <= '0;
`endif
                    end else if (!IN_TX_ACTIVE) begin
                        OUT_TX_LAUNCH <= 1'b1;
                        state         <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    OUT_TX_LAUNCH <= 1'b0;
                    if (IN_TX_DONE) begin
                        state <= WAIT_RX;
`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
                        timeout_cnt_q <= '0;
`endif
                    end
                end
                WAIT_RX: begin
                    if (rx_done) begin
                        OUT_RSP_RX_DATA <= IN_RX_DATA_MASSIV;
                        OUT_RSP_STATUS  <= rx_status;
                        OUT_RSP_VALID   <= 1'b1;
                        state           <= RESP;
                    end
`ifdef UART_MASSIV_CTRL_TIMEOUT_EN
                    else begin
                        timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (IN_RSP_READY) begin
                        OUT_RSP_VALID <= 1'b0;
                        OUT_REQ_READY <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
